// File: rtl/cnn_window_loader.sv
// cnn_window_loader
//   Input stage of the CNN datapath. Captures one pattern (CH x IMG x IMG
//   image words plus CH 2x2 kernels for two kernel sets and the padding
//   mode) and then serves padded 2x2 windows over a valid/ready handshake,
//   in the order channel, then row, then column.
//
//   Optional build macro: LOADER_ERR_EN adds a sticky protocol error
//   output 'err'. This flag is set when in_valid is seen during SERVE or
//   when in_valid drops in the middle of LOAD.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for beat 0 of a pattern
//   LOAD  | storing beats 1..74, one per cycle with in_valid high
//   SERVE | presenting windows, advancing on each accepted transfer
`timescale 1ns/1ps

module cnn_window_loader #(
    parameter int DW  = 32,
    parameter int IMG = 5,
    parameter int CH  = 3,
    parameter int KS  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [DW-1:0]   Img,
    input  logic [DW-1:0]   Kernel_ch1,
    input  logic [DW-1:0]   Kernel_ch2,
    input  logic            Opt,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [1:0]      win_ch,
    output logic [2:0]      win_row,
    output logic [2:0]      win_col,
    output logic [4*DW-1:0] win_pix,
    output logic [4*DW-1:0] win_k1,
    output logic [4*DW-1:0] win_k2,
    output logic            done
`ifdef LOADER_ERR_EN
    ,
    output logic            err
`endif
);

    localparam int KK     = KS * KS;
    localparam int NBEATS = CH * IMG * IMG;
    localparam int KBEATS = CH * KK;
    localparam int PAD_N  = IMG + 3 - KS;
    localparam int IW     = $clog2(NBEATS);
    localparam int KW     = $clog2(KBEATS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   cnt_q;
    logic            opt_q;
    logic            win_valid_q;
    logic            done_q;
    logic [1:0]      win_ch_q;
    logic [2:0]      win_row_q;
    logic [2:0]      win_col_q;
    logic [4*DW-1:0] win_pix_q;
    logic [4*DW-1:0] win_k1_q;
    logic [4*DW-1:0] win_k2_q;

    logic [DW-1:0]   img_q [NBEATS];
    logic [DW-1:0]   k1_q  [KBEATS];
    logic [DW-1:0]   k2_q  [KBEATS];

    logic            ld_en;
    logic            last_win;
    logic [1:0]      sel_ch;
    logic [2:0]      sel_row;
    logic [2:0]      sel_col;
    logic [4*DW-1:0] nxt_pix;
    logic [4*DW-1:0] nxt_k1;
    logic [4*DW-1:0] nxt_k2;

    // A beat is stored whenever the loader is still collecting a pattern;
    // in IDLE the counter is always 0, so beat 0 lands at index 0.
    assign ld_en = in_valid && ((state_q == S_IDLE) || (state_q == S_LOAD));

    assign last_win = (win_ch_q == 2'(CH - 1)) && (win_row_q == 3'(PAD_N - 1)) &&
                      (win_col_q == 3'(PAD_N - 1));

    // Next window position: (0,0,0) when entering SERVE, otherwise the
    // successor of the window currently on the outputs.
    always_comb begin
        sel_ch  = '0;
        sel_row = '0;
        sel_col = '0;
        if (state_q == S_SERVE) begin
            sel_ch  = win_ch_q;
            sel_row = win_row_q;
            sel_col = win_col_q + 3'd1;
            if (win_col_q == 3'(PAD_N - 1)) begin
                sel_col = '0;
                sel_row = win_row_q + 3'd1;
                if (win_row_q == 3'(PAD_N - 1)) begin
                    sel_row = '0;
                    sel_ch  = win_ch_q + 2'd1;
                end
            end
        end
    end

    // Gather the padded window and kernels for the selected position.
    // Coordinates are always clamped so the array read stays in range;
    // zero padding then masks any tap whose clamped position moved.
    always_comb begin
        nxt_pix = '0;
        nxt_k1  = '0;
        nxt_k2  = '0;
        for (int i = 0; i < KK; i++) begin
            int pr, pc, prc, pcc;
            logic out_of_img;
            pr  = int'(sel_row) + (i / KS) - 1;
            pc  = int'(sel_col) + (i % KS) - 1;
            prc = (pr < 0) ? 0 : ((pr > IMG - 1) ? IMG - 1 : pr);
            pcc = (pc < 0) ? 0 : ((pc > IMG - 1) ? IMG - 1 : pc);
            out_of_img = (pr != prc) || (pc != pcc);
            if (opt_q || !out_of_img) begin
                nxt_pix[i*DW +: DW] = img_q[IW'(int'(sel_ch) * IMG * IMG + prc * IMG + pcc)];
            end
            nxt_k1[i*DW +: DW] = k1_q[KW'(int'(sel_ch) * KK + i)];
            nxt_k2[i*DW +: DW] = k2_q[KW'(int'(sel_ch) * KK + i)];
        end
    end

    // Pattern storage; contents are only meaningful once fully loaded.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            img_q[cnt_q] <= Img;
            if (cnt_q < IW'(KBEATS)) begin
                k1_q[cnt_q[KW-1:0]] <= Kernel_ch1;
                k2_q[cnt_q[KW-1:0]] <= Kernel_ch2;
            end
        end
    end

    // Sequencer: beat counting, window stepping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opt_q       <= 1'b0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            win_ch_q    <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_pix_q   <= '0;
            win_k1_q    <= '0;
            win_k2_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        opt_q   <= Opt;
                        cnt_q   <= IW'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (cnt_q == IW'(NBEATS - 1)) begin
                            cnt_q       <= '0;
                            state_q     <= S_SERVE;
                            win_valid_q <= 1'b1;
                            win_ch_q    <= sel_ch;
                            win_row_q   <= sel_row;
                            win_col_q   <= sel_col;
                            win_pix_q   <= nxt_pix;
                            win_k1_q    <= nxt_k1;
                            win_k2_q    <= nxt_k2;
                        end else begin
                            cnt_q <= cnt_q + IW'(1);
                        end
                    end
                end
                S_SERVE: begin
                    if (win_valid_q && win_ready) begin
                        if (last_win) begin
                            win_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            win_ch_q  <= sel_ch;
                            win_row_q <= sel_row;
                            win_col_q <= sel_col;
                            win_pix_q <= nxt_pix;
                            win_k1_q  <= nxt_k1;
                            win_k2_q  <= nxt_k2;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_ERR_EN
    logic err_q;

    // Sticky protocol error: unexpected beat in SERVE or a hole in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((state_q == S_SERVE && in_valid) || (state_q == S_LOAD && !in_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign win_valid = win_valid_q;
    assign win_ch    = win_ch_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign win_pix   = win_pix_q;
    assign win_k1    = win_k1_q;
    assign win_k2    = win_k2_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cnn_window_loader.sv
// Testbench for cnn_window_loader: drives whole patterns and compares every
// presented window against a reference built from image/kernel arrays.
`timescale 1ns/1ps

module tb_cnn_window_loader;

    localparam int DW   = 32;
    localparam int NWIN = 108;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   Img = '0;
    logic [DW-1:0]   K1 = '0;
    logic [DW-1:0]   K2 = '0;
    logic            Opt = 1'b0;
    logic            win_ready = 1'b0;
    logic            win_valid;
    logic [1:0]      win_ch;
    logic [2:0]      win_row;
    logic [2:0]      win_col;
    logic [4*DW-1:0] win_pix;
    logic [4*DW-1:0] win_k1;
    logic [4*DW-1:0] win_k2;
    logic            done;
`ifdef LOADER_ERR_EN
    logic            err;
`endif

    cnn_window_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .Img        (Img),
        .Kernel_ch1 (K1),
        .Kernel_ch2 (K2),
        .Opt        (Opt),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_ch     (win_ch),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_pix    (win_pix),
        .win_k1     (win_k1),
        .win_k2     (win_k2),
        .done       (done)
`ifdef LOADER_ERR_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              ch;
        int              row;
        int              col;
        logic [4*DW-1:0] pix;
        logic [4*DW-1:0] k1;
        logic [4*DW-1:0] k2;
    } win_t;

    win_t          expq[$];
    logic [DW-1:0] img_m [3][5][5];
    logic [DW-1:0] k1m [3][4];
    logic [DW-1:0] k2m [3][4];
    bit            opt_m;
    int            n_pass = 0;
    int            n_tot  = 0;

    task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference pixel straight from the padding rules.
    function automatic logic [DW-1:0] ref_pix(int ch, int r, int c, int dr, int dc);
        int pr, pc;
        pr = r + dr - 1;
        pc = c + dc - 1;
        if (opt_m) begin
            if (pr < 0) pr = 0;
            if (pr > 4) pr = 4;
            if (pc < 0) pc = 0;
            if (pc > 4) pc = 4;
        end else if (pr < 0 || pr > 4 || pc < 0 || pc > 4) begin
            return '0;
        end
        return img_m[ch][pr][pc];
    endfunction

    task automatic gen(input bit rnd);
        int k1f[12] = '{1, 2, 1, 2, 2, 3, 2, 3, 3, 4, 3, 4};
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    img_m[ch][r][c] = rnd ? $urandom : DW'(r + c + 1);
            for (int p = 0; p < 4; p++) begin
                k1m[ch][p] = rnd ? $urandom : DW'(k1f[ch*4+p]);
                k2m[ch][p] = rnd ? $urandom : DW'(100 + ch*4 + p);
            end
        end
    endtask

    task automatic build();
        win_t w;
        expq.delete();
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) begin
                    w.ch = ch; w.row = r; w.col = c;
                    for (int i = 0; i < 4; i++) begin
                        w.pix[i*DW +: DW] = ref_pix(ch, r, c, i / 2, i % 2);
                        w.k1[i*DW +: DW]  = k1m[ch][i];
                        w.k2[i*DW +: DW]  = k2m[ch][i];
                    end
                    expq.push_back(w);
                end
    endtask

    // Streams 75 beats starting at the next falling edge; optional hole
    // of gap_len idle cycles before beat gap_at. Returns at the falling
    // edge right after beat 74 was sampled.
    task automatic load(input bit opt, input int gap_at, input int gap_len);
        opt_m = opt;
        build();
        win_ready = 1'b0;
        for (int k = 0; k < 75; k++) begin
            @(negedge clk);
            if (k == 0) chk("done_low_at_start", done, 0);
            if (k == gap_at) begin
                repeat (gap_len) begin
                    in_valid = 1'b0;
                    Img = $urandom;
                    @(negedge clk);
                    chk("no_valid_in_gap", win_valid, 0);
                end
            end
            if (k == 74) chk("no_valid_before_last_beat", win_valid, 0);
            in_valid = 1'b1;
            Img = img_m[k/25][(k%25)/5][k%5];
            K1  = (k < 12) ? k1m[k/4][k%4] : $urandom;
            K2  = (k < 12) ? k2m[k/4][k%4] : $urandom;
            Opt = (k == 0) ? opt : ~opt;
        end
        @(negedge clk);
        chk("valid_after_beat74", win_valid, 1);
        in_valid = 1'b0;
    endtask

    task automatic serve(input bit stall, input bit noise, input int spot, input int abort_at);
        int t = 0;
        int cyc = 0;
        bit fin = 1'b0;
        win_t e;
        while (!fin && cyc < 3000) begin
            cyc++;
            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", win_valid, 0);
                chk("rst_pix", win_pix, 0);
                chk("rst_k1k2", {win_k1, win_k2} == '0, 1);
                chk("rst_pos", {win_ch, win_row, win_col}, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                in_valid = 1'b0;
                fin = 1'b1;
            end else begin
                e = expq[t];
                chk($sformatf("valid w%0d", t), win_valid, 1);
                chk($sformatf("pos w%0d", t), {win_ch, win_row, win_col},
                    {2'(e.ch), 3'(e.row), 3'(e.col)});
                chk($sformatf("pix w%0d", t), win_pix, e.pix);
                chk($sformatf("k1 w%0d", t), win_k1, e.k1);
                chk($sformatf("k2 w%0d", t), win_k2, e.k2);
                if (spot == 1 && t == 0) begin
                    chk("t1_first_pix", win_pix, {4{32'd1}});
                    chk("t1_first_k1", win_k1, {32'd2, 32'd1, 32'd2, 32'd1});
                end
                if (spot == 1 && t == 15) chk("t1_w23_pix", win_pix, {32'd6, 32'd5, 32'd5, 32'd4});
                if (spot == 1 && t == 35) chk("t1_w55_pix", win_pix, {4{32'd9}});
                if (spot == 2 && t == 0)  chk("t2_w00_pix", win_pix, {32'd1, 96'd0});
                if (spot == 2 && t == 35) chk("t2_w55_pix", win_pix, {96'd0, 32'd9});
                if (spot == 2 && t == 72) chk("t2_ch2_k1", win_k1, {32'd4, 32'd3, 32'd4, 32'd3});
                win_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                Img = $urandom;
                K1  = $urandom;
                if (win_ready) t++;
                if (t == NWIN) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    chk("done_pulse", done, 1);
                    chk("valid_low_after_last", win_valid, 0);
                    win_ready = 1'b0;
                    fin = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        chk("serve_finished", fin, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: observed no end, required end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_valid", win_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_pos", {win_ch, win_row, win_col}, 0);
        chk("reset_pix", win_pix, 0);
`ifdef LOADER_ERR_EN
        chk("reset_err", err, 0);
`endif
        rst_n = 1'b1;

        // T1: replicate padding, fixed data
        gen(1'b0);
        load(1'b1, -1, 0);
        serve(1'b0, 1'b0, 1, -1);

        // T2: zero padding, fixed data
        gen(1'b0);
        load(1'b0, -1, 0);
        serve(1'b0, 1'b0, 2, -1);
`ifdef LOADER_ERR_EN
        chk("err_clean_run", err, 0);
`endif

        // T3: random data, random stalls, stray in_valid in SERVE
        gen(1'b1);
        load(1'($urandom_range(0, 1)), -1, 0);
        serve(1'b1, 1'b1, 0, -1);

        // T4: hole of 3 cycles at beat 40
        gen(1'b0);
        load(1'b1, 40, 3);
        serve(1'b0, 1'b0, 1, -1);
`ifdef LOADER_ERR_EN
        chk("err_after_hole", err, 1);
`endif

        // T5: reset at window 50, then fresh zero-padded pattern
        gen(1'b0);
        load(1'b1, -1, 0);
        serve(1'b0, 1'b0, 0, 50);
`ifdef LOADER_ERR_EN
        chk("err_cleared_by_reset", err, 0);
`endif
        gen(1'b0);
        load(1'b0, -1, 0);
        serve(1'b0, 1'b0, 2, -1);

        // T6: back-to-back random patterns with padding mode flipped
        gen(1'b1);
        load(1'b1, -1, 0);
        serve(1'b0, 1'b0, 0, -1);
        gen(1'b1);
        load(1'b0, -1, 0);
        serve(1'b1, 1'b0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
